// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//
// Sequences the alarm once the clock time matches the alarm time. Rings with
// a 1 s on / 1 s off beep and display-blink pattern, allows a bounded number
// of snoozes, times out on its own and then locks out re-triggering until
// the matching minute has passed.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   tick_1hz    one-cycle pulse once per second
//   tone        audio-rate square wave
//   alarm_en    alarm enable (level); low forces IDLE
//   match       high while clock hh:mm equals alarm hh:mm
//   snooze_btn  debounced snooze button (level)
//   stop_btn    debounced stop button (level)
//   beep        gated tone to the beeper
//   display_en  1 = display lit, 0 = blanked
//   ringing     state is RING
//   snoozing    state is SNOOZE
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for alarm_en & match; snooze count cleared
// RING    | beeping/blinking, cnt counts elapsed seconds of this ring
// SNOOZE  | silent, cnt counts remaining snooze seconds
// LOCKOUT | rang or was stopped; wait for match to drop

module alarm_sequencer #(
    parameter int SNOOZE_SECONDS  = 540,
    parameter int TIMEOUT_SECONDS = 300,
    parameter int MAX_SNOOZE      = 3,
    parameter int COUNT_W         = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1hz,
    input  logic tone,
    input  logic alarm_en,
    input  logic match,
    input  logic snooze_btn,
    input  logic stop_btn,
    output logic beep,
    output logic display_en,
    output logic ringing,
    output logic snoozing
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RING    = 2'd1,
        S_SNOOZE  = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0] SNOOZE_LOAD  = COUNT_W'(SNOOZE_SECONDS);
    localparam logic [COUNT_W-1:0] TIMEOUT_LAST = COUNT_W'(TIMEOUT_SECONDS - 1);
    localparam logic [COUNT_W-1:0] CNT_ONE      = COUNT_W'(1);
    localparam logic [3:0]         SNOOZE_LIMIT = 4'(MAX_SNOOZE);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         snz_cnt_q, snz_cnt_d;
    logic               pattern_q, pattern_d;
    logic               snooze_btn_q, stop_btn_q;
    logic               snooze_rise, stop_rise;

    // Button copies reset high so a button held through reset never
    // looks like a fresh press.
    assign snooze_rise = snooze_btn & ~snooze_btn_q;
    assign stop_rise   = stop_btn & ~stop_btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            snz_cnt_q    <= '0;
            pattern_q    <= 1'b0;
            snooze_btn_q <= 1'b1;
            stop_btn_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            pattern_q    <= pattern_d;
            snooze_btn_q <= snooze_btn;
            stop_btn_q   <= stop_btn;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snz_cnt_d = snz_cnt_q;
        pattern_d = pattern_q;

        case (state_q)
            S_IDLE: begin
                snz_cnt_d = '0;
                if (alarm_en && match) begin
                    state_d   = S_RING;
                    cnt_d     = '0;
                    pattern_d = 1'b1;
                end
            end
            S_RING: begin
                // Buttons win over a same-cycle tick, so a snooze load is
                // never decremented in the cycle it is taken.
                if (stop_rise) begin
                    state_d = S_LOCKOUT;
                end else if (snooze_rise && (snz_cnt_q < SNOOZE_LIMIT)) begin
                    state_d   = S_SNOOZE;
                    cnt_d     = SNOOZE_LOAD;
                    snz_cnt_d = snz_cnt_q + 4'd1;
                end else if (tick_1hz) begin
                    if (cnt_q == TIMEOUT_LAST) begin
                        state_d = S_LOCKOUT;
                    end else begin
                        cnt_d     = cnt_q + CNT_ONE;
                        pattern_d = ~pattern_q;
                    end
                end
            end
            S_SNOOZE: begin
                if (stop_rise) begin
                    state_d = S_LOCKOUT;
                end else if (tick_1hz) begin
                    // <= 1 rather than == 1 keeps cnt from ever wrapping.
                    if (cnt_q <= CNT_ONE) begin
                        state_d   = S_RING;
                        cnt_d     = '0;
                        pattern_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_LOCKOUT: begin
                if (!match) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!alarm_en) begin
            state_d = S_IDLE;
        end
    end

    assign ringing    = (state_q == S_RING);
    assign snoozing   = (state_q == S_SNOOZE);
    assign beep       = ringing & pattern_q & tone;
    assign display_en = ~(ringing & ~pattern_q);

endmodule

// File: tb/tb_alarm_sequencer.sv
module tb_alarm_sequencer;

    localparam int SNZ = 3;
    localparam int TMO = 4;
    localparam int MAXS = 1;

    logic clk, rst, tick_1hz, tone, alarm_en, match, snooze_btn, stop_btn;
    logic beep, display_en, ringing, snoozing;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic chk_en = 1'b0;
    int tone_div = 0;

    // Behavioural model: what the alarm is doing, how long the current ring
    // has lasted, how many snooze seconds remain, how many snoozes used.
    bit m_ring = 0, m_snz = 0, m_lock = 0;
    int m_elapsed = 0, m_remain = 0, m_used = 0;
    bit m_prev_stp = 1, m_prev_snz = 1;

    alarm_sequencer #(
        .SNOOZE_SECONDS (SNZ),
        .TIMEOUT_SECONDS(TMO),
        .MAX_SNOOZE     (MAXS),
        .COUNT_W        (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tone      (tone),
        .alarm_en  (alarm_en),
        .match     (match),
        .snooze_btn(snooze_btn),
        .stop_btn  (stop_btn),
        .beep      (beep),
        .display_en(display_en),
        .ringing   (ringing),
        .snoozing  (snoozing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tone = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tone_div++;
            if (tone_div == 2) begin
                tone_div = 0;
                tone = ~tone;
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit stp_r, snz_r;
        if (rst) begin
            m_ring = 0; m_snz = 0; m_lock = 0;
            m_elapsed = 0; m_remain = 0; m_used = 0;
            m_prev_stp = 1; m_prev_snz = 1;
            return;
        end
        stp_r = stop_btn && !m_prev_stp;
        snz_r = snooze_btn && !m_prev_snz;
        m_prev_stp = stop_btn;
        m_prev_snz = snooze_btn;
        if (!m_ring && !m_snz && !m_lock) m_used = 0;
        if (!alarm_en) begin
            m_ring = 0; m_snz = 0; m_lock = 0;
        end else if (m_lock) begin
            if (!match) m_lock = 0;
        end else if (m_ring) begin
            if (stp_r) begin
                m_ring = 0; m_lock = 1;
            end else if (snz_r && m_used < MAXS) begin
                m_ring = 0; m_snz = 1; m_remain = SNZ; m_used++;
            end else if (tick_1hz) begin
                m_elapsed++;
                if (m_elapsed == TMO) begin
                    m_ring = 0; m_lock = 1;
                end
            end
        end else if (m_snz) begin
            if (stp_r) begin
                m_snz = 0; m_lock = 1;
            end else if (tick_1hz) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_snz = 0; m_ring = 1; m_elapsed = 0;
                end
            end
        end else if (match) begin
            m_ring = 1; m_elapsed = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Lit (and beeping) on even seconds of a ring, blank on odd seconds.
    initial begin
        logic pat;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                pat = ((m_elapsed % 2) == 0);
                chk("model_ringing", ringing, m_ring);
                chk("model_snoozing", snoozing, m_snz);
                chk("model_beep", beep, m_ring && pat && tone);
                chk("model_display_en", display_en, !(m_ring && !pat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 0; alarm_en = 0; match = 0;
        snooze_btn = 0; stop_btn = 0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        chk("rst_ringing", ringing, 1'b0);
        chk("rst_snoozing", snoozing, 1'b0);
        chk("rst_beep", beep, 1'b0);
        chk("rst_display_en", display_en, 1'b1);
        rst = 1'b0;

        // Disabled alarm never rings.
        match = 1'b1;
        repeat (5) begin
            do_tick();
            chk("dis_ringing", ringing, 1'b0);
            chk("dis_display_en", display_en, 1'b1);
        end

        // Ring pattern.
        alarm_en = 1'b1;
        step();
        chk("ring_start", ringing, 1'b1);
        chk("ring_beep_tone", beep, tone);
        do_tick();
        chk("tick1_beep", beep, 1'b0);
        chk("tick1_display", display_en, 1'b0);
        do_tick();
        chk("tick2_display", display_en, 1'b1);
        chk("tick2_beep_tone", beep, tone);

        // Snooze, then the snooze limit.
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
        chk("snz_snoozing", snoozing, 1'b1);
        chk("snz_beep", beep, 1'b0);
        chk("snz_display", display_en, 1'b1);
        do_tick();
        do_tick();
        chk("snz_after2", snoozing, 1'b1);
        do_tick();
        chk("snz_after3_ring", ringing, 1'b1);
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
        chk("snz_limit_ring", ringing, 1'b1);
        chk("snz_limit_nosnz", snoozing, 1'b0);

        // Timeout and lockout.
        repeat (3) do_tick();
        chk("tmo_before", ringing, 1'b1);
        do_tick();
        chk("tmo_after", ringing, 1'b0);
        repeat (3) step();
        chk("lockout_hold", ringing, 1'b0);
        match = 1'b0;
        step();
        chk("lockout_release", ringing, 1'b0);
        match = 1'b1;
        step();
        chk("rearm_ring", ringing, 1'b1);

        // Stop beats snooze; held button through reset.
        stop_btn = 1'b1;
        snooze_btn = 1'b1;
        step();
        chk("stop_snz_ringing", ringing, 1'b0);
        chk("stop_snz_snoozing", snoozing, 1'b0);
        step();
        chk("stop_snz_stay", snoozing, 1'b0);
        stop_btn = 1'b0;
        snooze_btn = 1'b0;
        match = 1'b0;
        step();
        stop_btn = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        match = 1'b1;
        step();
        chk("held_ring", ringing, 1'b1);
        repeat (3) step();
        chk("held_no_stop", ringing, 1'b1);
        stop_btn = 1'b0;
        step();

        // Disable, then reset mid-snooze.
        alarm_en = 1'b0;
        step();
        chk("disable_ring", ringing, 1'b0);
        alarm_en = 1'b1;
        step();
        chk("reenable_ring", ringing, 1'b1);
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
        chk("mid_snz", snoozing, 1'b1);
        do_tick();
        chk("mid_snz_tick", snoozing, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_snz", snoozing, 1'b0);
        chk("async_rst_ring", ringing, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ring", ringing, 1'b1);
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
        chk("post_rst_snz_ok", snoozing, 1'b1);
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Sequences the alarm once the clock time matches the alarm time. It rings with a 1 s on / 1 s off beep and display-blink pattern, supports a bounded number of snoozes, times out automatically, and locks out re-triggering for the rest of the matching minute. It sits between the time/alarm comparator and the beeper and display-enable inputs of the output shift-register path, and runs on the system clock with 1 Hz tick enables from the clock divider.

## Interface
- SNOOZE_SECONDS, 540: snooze duration in ticks; 1..2^COUNT_W-1.
- TIMEOUT_SECONDS, 300: maximum continuous ring duration in ticks; 1..2^COUNT_W-1.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; 0..15.
- COUNT_W, 10: width of the seconds counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- tick_1hz  in  1  one-cycle pulse, once per second.
- tone  in  1  audio-rate square wave from the divider.
- alarm_en  in  1  alarm enable (level).
- match  in  1  level; high while clock hours:minutes equal alarm hours:minutes.
- snooze_btn  in  1  debounced snooze button (level).
- stop_btn  in  1  debounced stop button (level).
- beep  out  1  gated tone to the beeper.
- display_en  out  1  1 = display lit, 0 = blanked.
- ringing  out  1  state == RING.
- snoozing  out  1  state == SNOOZE.

## Operation
- **Button edge detection**
  - Each button has a registered copy, and rise = btn & ~btn_q.
  - The copies reset to 1, so a button held through reset produces no edge.
- **State register:** IDLE, RING, SNOOZE, LOCKOUT. The other registers are cnt[COUNT_W-1:0], snz_cnt[3:0] and pattern.
- **Global rule:** alarm_en=0 forces IDLE from any state. This has the highest priority.
- **IDLE**
  - Moves to RING when alarm_en & match.
  - On entry to RING: cnt=0, pattern=1.
  - snz_cnt=0 while in IDLE.
- **RING** (priority order after alarm_en):
  - stop rise → LOCKOUT.
  - snooze rise with snz_cnt < MAX_SNOOZE → SNOOZE, cnt=SNOOZE_SECONDS, snz_cnt+1.
  - snooze rise with snz_cnt == MAX_SNOOZE is ignored.
  - On tick with cnt == TIMEOUT_SECONDS-1 → LOCKOUT.
  - Otherwise, on tick: cnt+1 and pattern toggles.
  - match falling during RING has no effect.
- **SNOOZE**
  - stop rise → LOCKOUT.
  - snooze rise is ignored.
  - On tick with cnt == 1 → RING, with cnt=0, pattern=1.
  - Otherwise, on tick: cnt−1.
- **LOCKOUT:** moves to IDLE when match=0.
- **Outputs**
  - beep = (state==RING) & pattern & tone. This is combinational from tone and registered pattern.
  - display_en = ~((state==RING) & ~pattern).
  - ringing and snoozing are decoded from the state register.
- **Counters**
  - cnt never wraps.
  - snz_cnt saturates at MAX_SNOOZE.

## Timing
- **Reset values:** state=IDLE, cnt=0, snz_cnt=0, pattern=0, beep=0, display_en=1, ringing=0, snoozing=0.
- **Reset mid-operation:** reset asserted in any state returns to IDLE immediately (asynchronous), with the reset values above.
- **Transition latency:** all transitions are registered and take effect one clk after the sampled condition.
  - ringing rises the cycle after alarm_en & match are first sampled high.
  - beep follows tone combinationally from that cycle on.
- **Button latency:** a button edge acts one cycle after the btn level rises, because of the edge register. Held buttons act once.
- **Ring length:** RING without input lasts exactly TIMEOUT_SECONDS ticks.
  - pattern is 1 for the first second and then alternates every tick.
- **Snooze length:** SNOOZE lasts exactly SNOOZE_SECONDS ticks, then rings with a fresh timeout.
- **Simultaneous events:**
  - alarm_en=0 beats everything.
  - stop beats snooze.
  - stop or snooze beats tick/timeout in the same cycle.
  - A tick coinciding with snooze does not decrement the freshly loaded cnt.
- **Lockout release:** LOCKOUT releases the cycle after match is sampled low. If match and alarm_en are high again later, IDLE → RING re-arms normally.

## Test plan
All scenarios use SNOOZE_SECONDS=3, TIMEOUT_SECONDS=4, MAX_SNOOZE=1.

1. **Reset and disabled alarm:** pulse rst, then alarm_en=0, match=1, 5 ticks → beep=0, display_en=1, ringing=0, snoozing=0 throughout.
2. **Ring pattern:** alarm_en=1, match=1 → ringing=1 next cycle, beep==tone.
   - tick 1 → beep=0, display_en=0.
   - tick 2 → beep==tone, display_en=1.
3. **Snooze and snooze limit:** while ringing, snooze rise → snoozing=1, beep=0, display_en=1.
   - After exactly 3 ticks → ringing=1.
   - A second snooze rise is ignored and ringing stays 1.
4. **Timeout and lockout:** ring 4 ticks with no buttons → ringing=0 (LOCKOUT), and no re-ring while match=1.
   - match=0 → IDLE.
   - match=1 → ringing=1.
5. **Stop/snooze priority and held button:** stop and snooze rising in the same cycle → LOCKOUT, snoozing=0.
   - stop_btn held high through rst release, then match=1 → rings, and the held button causes no stop.
6. **Disable and mid-snooze reset:** alarm_en=0 during RING → ringing=0 next cycle.
   - rst asserted mid-SNOOZE → snoozing=0 immediately, with cnt and snz_cnt cleared (the next alarm event allows a snooze again).
